mem_access_unit: RTL and testbench

- Memory-stage load/store engine of the pipelined RV32I core, sitting directly upstream of the writeback rd select.
- Takes the EX/MEM load/store request and runs a req/ack handshake with data memory.
- Generates byte enables and store-data lanes, aligns and sign/zero-extends load data, and stalls the pipeline until the access completes.
- Its loadData output is the dataMem operand consumed at writeback.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_access_unit_load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store engine: RV32I funct3
// encodings, FSM state encoding and the default request timeout.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int DEFAULT_MAX_WAIT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Loads accept all five RV32I load encodings; stores accept only SB/SH/SW.
   function automatic logic f3_supported(input logic is_load, input logic [2:0] f3);
      if (is_load)
         return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: picks the addressed byte/half/word out of the memory
// read word and sign- or zero-extends it according to funct3.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every always_comb output gets a value on every path (defaults or a
   // full case with default) so no latch is inferred.
   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase

      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'd0, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'd0, half_sel};
         F3_W:    result = rdata;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: req/ack handshake with data memory, byte
// lanes, load alignment and pipeline stall. Optional macro: MISALIGN_TRAP_EN.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       storeData,
   output logic              stall,
   output logic [31:0]       loadData,
   output logic              done,
   output logic              busErr,
   output logic              misaligned,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [3:0]        memBe,
   output logic [31:0]       memWdata,
   input  logic              memAck,
   input  logic [31:0]       memRdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   state_t              state, state_next;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [1:0]          lat_off;
   logic [2:0]          lat_f3;
   logic                mis_flag;
   logic                access, bad_f3, mis_hit, timeout;
   logic [3:0]          req_be;
   logic [31:0]         req_wdata;
   logic [31:0]         aligned;

   assign access     = valid & (memRead | memWrite);
   assign bad_f3     = !f3_supported(memRead, funct3);
   assign timeout    = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
   assign stall      = access & (state != RESP);
   assign done       = (state == RESP);
   assign misaligned = mis_flag;

`ifdef MISALIGN_TRAP_EN
   assign mis_hit = ((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
   assign mis_hit = 1'b0;
`endif

   always_comb begin
      req_be    = 4'b1111;
      req_wdata = storeData;
      if (memWrite & !memRead) begin
         case (funct3[1:0])
            2'b00: begin
               req_be    = 4'b0001 << addr[1:0];
               req_wdata = {4{storeData[7:0]}};
            end
            2'b01: begin
               req_be    = addr[1] ? 4'b1100 : 4'b0011;
               req_wdata = {2{storeData[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (access) state_next = (bad_f3 | mis_hit) ? RESP : REQ;
         REQ:     if (memAck | timeout) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   load_align u_load_align (
      .rdata  (memRdata),
      .offset (lat_off),
      .funct3 (lat_f3),
      .result (aligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memBe    <= '0;
         memWdata <= '0;
         loadData <= '0;
         busErr   <= 1'b0;
         mis_flag <= 1'b0;
         wait_cnt <= '0;
         lat_off  <= '0;
         lat_f3   <= '0;
      end else begin
         case (state)
            IDLE: if (access) begin
               if (bad_f3) begin
                  busErr   <= 1'b1;
                  loadData <= '0;
               end else if (mis_hit) begin
                  mis_flag <= 1'b1;
                  loadData <= '0;
               end else begin
                  memReq   <= 1'b1;
                  memWe    <= !memRead;
                  memAddr  <= {addr[ADDR_W-1:2], 2'b00};
                  memBe    <= req_be;
                  memWdata <= req_wdata;
                  lat_off  <= addr[1:0];
                  lat_f3   <= funct3;
                  wait_cnt <= '0;
               end
            end
            REQ: begin
               if (memAck) begin
                  memReq <= 1'b0;
                  if (!memWe) loadData <= aligned;
               end else if (timeout) begin
                  memReq   <= 1'b0;
                  busErr   <= 1'b1;
                  loadData <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            RESP: begin
               busErr   <= 1'b0;
               mis_flag <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit; honours MISALIGN_TRAP_EN if defined.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst, valid, memRead, memWrite, memAck;
   logic [2:0]  funct3;
   logic [31:0] addr, storeData, memRdata;
   logic        stall, done, busErr, misaligned, memReq, memWe;
   logic [31:0] loadData, memAddr, memWdata;
   logic [3:0]  memBe;

   int tests_run    = 0;
   int tests_failed = 0;

   // Observations from the last run_access call
   int          o_lat, o_stall_cnt, o_req_cnt;
   logic        o_req_seen, o_we, o_err, o_mis, o_req_at_done;
   logic [31:0] o_addr, o_wdata, o_ld;
   logic [3:0]  o_be;

   always #5 clk = ~clk;

   mem_access_unit #(.MAX_WAIT(15), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .valid(valid), .memRead(memRead), .memWrite(memWrite),
      .funct3(funct3), .addr(addr), .storeData(storeData), .stall(stall),
      .loadData(loadData), .done(done), .busErr(busErr), .misaligned(misaligned),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
      .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata)
   );

   // Presents one access, answers memAck after ack_delay REQ cycles (never if
   // negative) and records what it saw; cycle 0 is the presentation cycle.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdata, input int ack_delay);
      int req_cycles;
      req_cycles = 0;
      o_lat = -1; o_stall_cnt = 0; o_req_cnt = 0; o_req_seen = 1'b0;
      o_addr = '0; o_be = '0; o_we = 1'b0; o_wdata = '0; o_ld = 32'hXXXXXXXX;
      o_err = 1'b0; o_mis = 1'b0; o_req_at_done = 1'b1;
      @(posedge clk); #1;
      valid = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; addr = a;
      storeData = sd; memAck = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stall) o_stall_cnt++;
         if (done) begin
            o_lat = c; o_ld = loadData; o_err = busErr; o_mis = misaligned;
            o_req_at_done = memReq;
            break;
         end
         if (memReq) begin
            if (!o_req_seen) begin
               o_req_seen = 1'b1; o_addr = memAddr; o_be = memBe;
               o_we = memWe; o_wdata = memWdata;
            end
            o_req_cnt++;
            memAck   = (req_cycles == ack_delay);
            memRdata = memAck ? rdata : 32'h5A5A5A5A;
            req_cycles++;
         end else begin
            memAck = 1'b0;
         end
      end
      @(posedge clk); #1;
      valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memAck = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = '0;
      addr = '0; storeData = '0; memAck = 1'b0; memRdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({stall, done, busErr, misaligned, memReq, memWe} !== 6'b0 ||
          loadData !== 32'h0 || memAddr !== 32'h0 || memBe !== 4'h0 || memWdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got ctl=%b ld=%h addr=%h be=%h wd=%h want all zero",
                  {stall, done, busErr, misaligned, memReq, memWe}, loadData, memAddr, memBe, memWdata);
      end
   endtask

   task automatic test_lw;
      run_access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      tests_run++;
      if (o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_request: got addr=%h be=%h we=%b want 00000100 f 0", o_addr, o_be, o_we);
      end
      tests_run++;
      if (o_lat !== 2 || o_stall_cnt !== 2) begin
         tests_failed++;
         $display("FAIL lw_latency: got done_at=%0d stall_cycles=%0d want 2 2", o_lat, o_stall_cnt);
      end
      tests_run++;
      if (o_ld !== 32'hDEADBEEF || o_err !== 1'b0 || o_req_at_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_data: got ld=%h err=%b req=%b want deadbeef 0 0", o_ld, o_err, o_req_at_done);
      end
   endtask

   task automatic test_load_extend;
      run_access(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF0000, 0);
      tests_run++;
      if (o_ld !== 32'hFFFFFF80 || o_addr !== 32'h100) begin
         tests_failed++;
         $display("FAIL lb_sext: got ld=%h addr=%h want ffffff80 00000100", o_ld, o_addr);
      end
      run_access(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF0000, 0);
      tests_run++;
      if (o_ld !== 32'h00000080) begin
         tests_failed++;
         $display("FAIL lbu_zext: got %h want 00000080", o_ld);
      end
      run_access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h80FF0000, 1);
      tests_run++;
      if (o_ld !== 32'hFFFF80FF || o_lat !== 3) begin
         tests_failed++;
         $display("FAIL lh_sext: got ld=%h done_at=%0d want ffff80ff 3", o_ld, o_lat);
      end
      run_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF0000, 0);
      tests_run++;
      if (o_ld !== 32'h000080FF) begin
         tests_failed++;
         $display("FAIL lhu_zext: got %h want 000080ff", o_ld);
      end
   endtask

   task automatic test_store;
      run_access(1'b0, 1'b1, F3_B, 32'h201, 32'h12345678, 32'h0, 0);
      tests_run++;
      if (o_addr !== 32'h200 || o_be !== 4'b0010 || o_wdata !== 32'h78787878 || o_we !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_lanes: got addr=%h be=%b wd=%h we=%b want 00000200 0010 78787878 1",
                  o_addr, o_be, o_wdata, o_we);
      end
      tests_run++;
      if (o_ld !== 32'h000080FF || o_lat !== 2) begin
         tests_failed++;
         $display("FAIL sb_keeps_load: got ld=%h done_at=%0d want 000080ff 2", o_ld, o_lat);
      end
      run_access(1'b0, 1'b1, F3_H, 32'h202, 32'h12345678, 32'h0, 0);
      tests_run++;
      if (o_be !== 4'b1100 || o_wdata !== 32'h56785678) begin
         tests_failed++;
         $display("FAIL sh_lanes: got be=%b wd=%h want 1100 56785678", o_be, o_wdata);
      end
      run_access(1'b0, 1'b1, F3_W, 32'h204, 32'h12345678, 32'h0, 0);
      tests_run++;
      if (o_be !== 4'hF || o_wdata !== 32'h12345678 || o_addr !== 32'h204) begin
         tests_failed++;
         $display("FAIL sw_lanes: got be=%h wd=%h addr=%h want f 12345678 00000204", o_be, o_wdata, o_addr);
      end
   endtask

   task automatic test_timeout;
      run_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'h0, -1);
      tests_run++;
      if (o_req_cnt !== 15 || o_lat !== 16 || o_req_at_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_timing: got req_cycles=%0d done_at=%0d req=%b want 15 16 0",
                  o_req_cnt, o_lat, o_req_at_done);
      end
      tests_run++;
      if (o_err !== 1'b1 || o_ld !== 32'h0) begin
         tests_failed++;
         $display("FAIL timeout_err: got err=%b ld=%h want 1 00000000", o_err, o_ld);
      end
   endtask

   task automatic test_back_to_back;
      run_access(1'b1, 1'b0, F3_W, 32'h104, 32'h0, 32'hCAFEF00D, 2);
      tests_run++;
      if (o_ld !== 32'hCAFEF00D || o_err !== 1'b0 || o_lat !== 4 || o_stall_cnt !== 4) begin
         tests_failed++;
         $display("FAIL after_timeout: got ld=%h err=%b done_at=%0d stall=%0d want cafef00d 0 4 4",
                  o_ld, o_err, o_lat, o_stall_cnt);
      end
   endtask

   task automatic test_bad_funct3;
      run_access(1'b1, 1'b0, 3'b011, 32'h108, 32'h0, 32'h0, 0);
      tests_run++;
      if (o_req_seen !== 1'b0 || o_err !== 1'b1 || o_lat !== 1 || o_mis !== 1'b0) begin
         tests_failed++;
         $display("FAIL bad_load_f3: got req=%b err=%b done_at=%0d mis=%b want 0 1 1 0",
                  o_req_seen, o_err, o_lat, o_mis);
      end
      run_access(1'b0, 1'b1, F3_BU, 32'h108, 32'h0, 32'h0, 0);
      tests_run++;
      if (o_req_seen !== 1'b0 || o_err !== 1'b1 || o_lat !== 1) begin
         tests_failed++;
         $display("FAIL bad_store_f3: got req=%b err=%b done_at=%0d want 0 1 1", o_req_seen, o_err, o_lat);
      end
   endtask

   task automatic test_reset_mid;
      // Leave a known non-zero load result behind first
      run_access(1'b1, 1'b0, F3_W, 32'h10C, 32'h0, 32'h0BADF00D, 0);
      @(posedge clk); #1;
      valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = F3_W; addr = 32'h400; memAck = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (memReq !== 1'b1 || memAddr !== 32'h400) begin
         tests_failed++;
         $display("FAIL pre_reset_req: got req=%b addr=%h want 1 00000400", memReq, memAddr);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (memReq !== 1'b0 || done !== 1'b0 || busErr !== 1'b0 || loadData !== 32'h0 ||
          memBe !== 4'h0 || memAddr !== 32'h0 || stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_reset: got req=%b done=%b err=%b ld=%h be=%h addr=%h stall=%b want 0 0 0 0 0 0 1",
                  memReq, done, busErr, loadData, memBe, memAddr, stall);
      end
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0; memRead = 1'b0;
      @(negedge clk);
      tests_run++;
      if (stall !== 1'b0 || memReq !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got stall=%b req=%b done=%b want 0 0 0", stall, memReq, done);
      end
   endtask

   task automatic test_misaligned;
      run_access(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 32'h13579BDF, 0);
`ifdef MISALIGN_TRAP_EN
      tests_run++;
      if (o_req_seen !== 1'b0 || o_mis !== 1'b1 || o_lat !== 1 || o_ld !== 32'h0 || o_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL misalign_trap: got req=%b mis=%b done_at=%0d ld=%h err=%b want 0 1 1 00000000 0",
                  o_req_seen, o_mis, o_lat, o_ld, o_err);
      end
`else
      tests_run++;
      if (o_addr !== 32'h100 || o_mis !== 1'b0 || o_lat !== 2 || o_ld !== 32'h13579BDF) begin
         tests_failed++;
         $display("FAIL misalign_ignored: got addr=%h mis=%b done_at=%0d ld=%h want 00000100 0 2 13579bdf",
                  o_addr, o_mis, o_lat, o_ld);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_extend();
      test_store();
      test_timeout();
      test_back_to_back();
      test_bad_funct3();
      test_reset_mid();
      test_misaligned();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
